hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Pipeline hazard and forwarding controller for the 5-stage MIPS core. Tracks destination-register state of the instructions in EX, MEM and WB in shadow registers. Drives the `Ai`/`Bi` forwarding selects consumed by the Execute stage, inserts load-use stalls, and flushes IF/ID and ID/EX on the Execute stage's `branch_taken`. Also maintains saturating stall/flush performance counters.

## Interface

Parameters:
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `id_rs`  in  5: rs field of the instruction in ID.
- `id_rt`  in  5: rt field of the instruction in ID.
- `id_dest`  in  5: destination register of the ID instruction (post-RegDst mux).
- `id_reg_write`  in  1: ID instruction writes the register file.
- `id_mem_read`  in  1: ID instruction is a load.
- `id_uses_rt`  in  1: ID instruction reads rt (R-type, store, beq/bne).
- `branch_taken`  in  1: from Execute; branch in EX resolved taken.
- `mem_stall`  in  1: data memory not ready; freezes the whole pipeline.
- `Ai`  out  2: EX operand-A select. 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write data.
- `Bi`  out  2: EX operand-B and store-data select; same encoding as `Ai`.
- `pc_write`  out  1: PC may update.
- `ifid_write`  out  1: IF/ID register may load.
- `ifid_flush`  out  1: IF/ID loads a NOP.
- `idex_bubble`  out  1: ID/EX loads a NOP.
- `stall_count`  out  CNT_W: number of load-use stall cycles, saturating.
- `flush_count`  out  CNT_W: number of branch flushes, saturating.

## Operation

- Shadow pipeline holds three stages:
  - EX stage: `ex_rs`, `ex_rt`, `ex_dest`, `ex_rw`, `ex_mr`.
  - MEM stage: `mem_dest`, `mem_rw`.
  - WB stage: `wb_dest`, `wb_rw`.
- Per-cycle priority is freeze > flush > load-use stall > normal.
- **Freeze** (`mem_stall` = 1):
  - All shadow state holds.
  - `pc_write` = `ifid_write` = 0; `ifid_flush` = `idex_bubble` = 0.
  - `branch_taken` is ignored this cycle; it re-asserts because the branch is still in EX.
  - Counters hold.
- **Flush** (`branch_taken` = 1, no freeze):
  - `ifid_flush` = `idex_bubble` = 1; `pc_write` = `ifid_write` = 1.
  - Shadow EX loads a bubble (`rw` = `mr` = 0, all fields 0); MEM←EX, WB←MEM.
  - `flush_count` += 1.
- **Load-use stall**: condition is `ex_mr` && `ex_dest` != 0 && (`ex_dest` == `id_rs` || (`id_uses_rt` && `ex_dest` == `id_rt`)).
  - `pc_write` = `ifid_write` = 0; `idex_bubble` = 1.
  - Shadow EX loads a bubble; MEM←EX, WB←MEM.
  - `stall_count` += 1.
- **Normal**:
  - EX←ID inputs, MEM←EX, WB←MEM.
  - `pc_write` = `ifid_write` = 1; `ifid_flush` = `idex_bubble` = 0.
- **Forwarding** is combinational from shadow state only:
  - `Ai` = 10 if `mem_rw` && `mem_dest` != 0 && `mem_dest` == `ex_rs`.
  - Else `Ai` = 01 if `wb_rw` && `wb_dest` != 0 && `wb_dest` == `ex_rs`.
  - Else `Ai` = 00.
  - `Bi` uses the same rule with `ex_rt`.
  - MEM beats WB, so the youngest producer wins.
- Register 0 never matches for either stall or forwarding.
- Counters saturate at all-ones and never wrap.

## Timing

- Reset values:
  - All shadow fields and `rw`/`mr` bits = 0.
  - `Ai` = `Bi` = 00.
  - `pc_write` = `ifid_write` = 1; `ifid_flush` = `idex_bubble` = 0.
  - Counters = 0.
- Reset has priority over `mem_stall`. Reset asserted mid-stall or mid-flush clears everything on that edge.
- `pc_write`, `ifid_write`, `ifid_flush` and `idex_bubble` are combinational in the same cycle as their cause; the pipeline registers act on the following edge.
- Load-use sequence:
  - Load in EX at cycle n → stall in cycle n.
  - Cycle n+1: load in MEM, bubble in EX; dependent still in ID, no stall.
  - Cycle n+2: dependent in EX, load in WB → `Ai`/`Bi` = 01.
  - Exactly one stall cycle per load-use hazard.
- ALU-to-ALU back-to-back dependency: no stall; `Ai`/`Bi` = 10 in the consumer's EX cycle.
- Forward selects change only on clock edges; they are stable for the whole cycle.

## Test plan

- **Reset:** hold `rst` for 2 cycles with random inputs → all outputs at reset values; counters = 0.
- **ALU forward:**
  - Push `add $3`, then `sub` with rs = 3 → `Ai` = 10 in sub's EX cycle.
  - Push `add $3`, nop, then `sub` with rs = 3 → `Ai` = 01.
  - Dest = $0 in either case → `Ai` = 00.
- **Load-use:** `lw $5`, then `add` with rt = 5 and `id_uses_rt` = 1 →
  - One cycle with `pc_write` = 0, `idex_bubble` = 1.
  - `stall_count` = 1.
  - Two cycles later `Bi` = 01.
  - Repeat with `id_uses_rt` = 0 → no stall.
- **Branch flush:** `branch_taken` = 1 for one cycle →
  - `ifid_flush` = `idex_bubble` = 1; `flush_count` = 1.
  - Next cycle the shadow EX is a bubble, so `Ai` = `Bi` = 00 against any rs/rt.
- **Freeze:** assert `mem_stall` for 3 cycles during a pending load-use and a taken branch →
  - `pc_write` = 0 throughout; counters unchanged; `Ai`/`Bi` constant.
  - After release, exactly one stall or one flush resolves as per priority.
- **Saturation:** preset by running `2^CNT_W` + 3 load-use stalls with `CNT_W` = 4 → `stall_count` = 15 and holds.

Source files
------------

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Purpose  : Hazard and forwarding controller for a 5-stage MIPS pipeline.
//            Shadows the destination-register state of the EX, MEM and WB
//            instructions. From that state it derives the EX operand forward
//            selects, load-use stalls and taken-branch flushes. It also keeps
//            saturating stall/flush performance counters.
// Ports    :
//   clk, rst          - clock; synchronous active-high reset
//   id_rs_i/id_rt_i   - source register fields of the ID instruction
//   id_dest_i         - destination register of the ID instruction
//   id_reg_write_i    - ID instruction writes the register file
//   id_mem_read_i     - ID instruction is a load
//   id_uses_rt_i      - ID instruction reads rt
//   branch_taken_i    - branch in EX resolved taken
//   mem_stall_i       - data memory not ready; freezes the pipeline
//   Ai_o/Bi_o         - EX operand selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   pc_write_o        - PC may update
//   ifid_write_o      - IF/ID may load
//   ifid_flush_o      - IF/ID loads a NOP
//   idex_bubble_o     - ID/EX loads a NOP
//   stall_count_o     - saturating count of load-use stall cycles
//   flush_count_o     - saturating count of branch flushes
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic [4:0]       id_dest_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic [1:0]       Ai_o,
  output logic [1:0]       Bi_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  // Per-cycle pipeline action, in priority order freeze > flush > stall > normal.
  localparam logic [1:0] c_MODE_NORMAL = 2'd0;
  localparam logic [1:0] c_MODE_STALL  = 2'd1;
  localparam logic [1:0] c_MODE_FLUSH  = 2'd2;
  localparam logic [1:0] c_MODE_FREEZE = 2'd3;

  localparam logic [1:0] c_SEL_RF  = 2'b00;
  localparam logic [1:0] c_SEL_MEM = 2'b10;
  localparam logic [1:0] c_SEL_WB  = 2'b01;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Shadow pipeline state
  logic [4:0] ex_rs_q,   ex_rs_d;
  logic [4:0] ex_rt_q,   ex_rt_d;
  logic [4:0] ex_dest_q, ex_dest_d;
  logic       ex_rw_q,   ex_rw_d;
  logic       ex_mr_q,   ex_mr_d;
  logic [4:0] mem_dest_q, mem_dest_d;
  logic       mem_rw_q,   mem_rw_d;
  logic [4:0] wb_dest_q,  wb_dest_d;
  logic       wb_rw_q,    wb_rw_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       w_load_use;
  logic [1:0] w_mode;

  // A load in EX whose (non-zero) destination is read by the ID instruction.
  // rt only counts when the ID instruction actually reads it.
  assign w_load_use = ex_mr_q && (ex_dest_q != 5'd0) &&
                      ((ex_dest_q == id_rs_i) ||
                       (id_uses_rt_i && (ex_dest_q == id_rt_i)));

  always_comb begin
    if (mem_stall_i)         w_mode = c_MODE_FREEZE;
    else if (branch_taken_i) w_mode = c_MODE_FLUSH;
    else if (w_load_use)     w_mode = c_MODE_STALL;
    else                     w_mode = c_MODE_NORMAL;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs_q     <= 5'd0;
      ex_rt_q     <= 5'd0;
      ex_dest_q   <= 5'd0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_dest_q  <= 5'd0;
      mem_rw_q    <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_dest_q   <= ex_dest_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_dest_q  <= mem_dest_d;
      mem_rw_q    <= mem_rw_d;
      wb_dest_q   <= wb_dest_d;
      wb_rw_q     <= wb_rw_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Default: hold everything (freeze)
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_dest_d   = ex_dest_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    mem_dest_d  = mem_dest_q;
    mem_rw_d    = mem_rw_q;
    wb_dest_d   = wb_dest_q;
    wb_rw_d     = wb_rw_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (w_mode != c_MODE_FREEZE) begin
      // MEM and WB advance whenever the pipeline is not frozen
      mem_dest_d = ex_dest_q;
      mem_rw_d   = ex_rw_q;
      wb_dest_d  = mem_dest_q;
      wb_rw_d    = mem_rw_q;

      if (w_mode == c_MODE_NORMAL) begin
        ex_rs_d   = id_rs_i;
        ex_rt_d   = id_rt_i;
        ex_dest_d = id_dest_i;
        ex_rw_d   = id_reg_write_i;
        ex_mr_d   = id_mem_read_i;
      end else begin
        // Flush and stall both inject a bubble into EX
        ex_rs_d   = 5'd0;
        ex_rt_d   = 5'd0;
        ex_dest_d = 5'd0;
        ex_rw_d   = 1'b0;
        ex_mr_d   = 1'b0;
      end

      if ((w_mode == c_MODE_STALL) && (stall_cnt_q != c_CNT_MAX))
        stall_cnt_d = stall_cnt_q + c_CNT_ONE;
      if ((w_mode == c_MODE_FLUSH) && (flush_cnt_q != c_CNT_MAX))
        flush_cnt_d = flush_cnt_q + c_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    case (w_mode)
      c_MODE_FREEZE: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end
      c_MODE_FLUSH: begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end
      c_MODE_STALL: begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Forwarding: registered state only, so selects are stable all cycle.
  // MEM is checked first so the youngest producer wins.
  // --------------------------------------------------------------------------
  always_comb begin
    if (mem_rw_q && (mem_dest_q != 5'd0) && (mem_dest_q == ex_rs_q))
      Ai_o = c_SEL_MEM;
    else if (wb_rw_q && (wb_dest_q != 5'd0) && (wb_dest_q == ex_rs_q))
      Ai_o = c_SEL_WB;
    else
      Ai_o = c_SEL_RF;

    if (mem_rw_q && (mem_dest_q != 5'd0) && (mem_dest_q == ex_rt_q))
      Bi_o = c_SEL_MEM;
    else if (wb_rw_q && (wb_dest_q != 5'd0) && (wb_dest_q == ex_rt_q))
      Bi_o = c_SEL_WB;
    else
      Bi_o = c_SEL_RF;
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_unit
// Purpose  : Directed self-checking bench for hazard_forward_unit, built with
//            4-bit counters so saturation is reachable quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, id_dest;
  logic             id_reg_write, id_mem_read, id_uses_rt;
  logic             branch_taken, mem_stall;
  logic [1:0]       Ai, Bi;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_total = 0;
  int n_pass  = 0;

  hazard_forward_unit #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_dest_i     (id_dest),
    .id_reg_write_i(id_reg_write),
    .id_mem_read_i (id_mem_read),
    .id_uses_rt_i  (id_uses_rt),
    .branch_taken_i(branch_taken),
    .mem_stall_i   (mem_stall),
    .Ai_o          (Ai),
    .Bi_o          (Bi),
    .pc_write_o    (pc_write),
    .ifid_write_o  (ifid_write),
    .ifid_flush_o  (ifid_flush),
    .idex_bubble_o (idex_bubble),
    .stall_count_o (stall_count),
    .flush_count_o (flush_count)
  );

  always #5 clk = ~clk;

  // Advance one edge, then sit 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in ID and let the combinational outputs settle.
  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dest, input logic rw,
                          input logic mr, input logic urt);
    id_rs = rs; id_rt = rt; id_dest = dest;
    id_reg_write = rw; id_mem_read = mr; id_uses_rt = urt;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; branch_taken = 1'b0; mem_stall = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      branch_taken = 1'($urandom_range(0, 1));
      mem_stall    = 1'($urandom_range(0, 1));
      drive_id(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1);
      tick();
    end
    rst = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0);
    n_total++; if (Ai !== 2'b00) $display("FAIL reset_Ai got=%b exp=00", Ai); else n_pass++;
    n_total++; if (Bi !== 2'b00) $display("FAIL reset_Bi got=%b exp=00", Bi); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL reset_pc_write got=%b exp=1", pc_write); else n_pass++;
    n_total++; if (ifid_write !== 1'b1) $display("FAIL reset_ifid_write got=%b exp=1", ifid_write); else n_pass++;
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL reset_ifid_flush got=%b exp=0", ifid_flush); else n_pass++;
    n_total++; if (idex_bubble !== 1'b0) $display("FAIL reset_idex_bubble got=%b exp=0", idex_bubble); else n_pass++;
    n_total++; if (stall_count !== 4'd0) $display("FAIL reset_stall_count got=%0d exp=0", stall_count); else n_pass++;
    n_total++; if (flush_count !== 4'd0) $display("FAIL reset_flush_count got=%0d exp=0", flush_count); else n_pass++;
  endtask

  task automatic test_alu_forward();
    // add $3 then sub rs=3: EX/MEM forward
    do_reset();
    drive_id(1, 2, 3, 1, 0, 1); tick();
    drive_id(3, 4, 6, 1, 0, 1); tick();
    n_total++; if (Ai !== 2'b10) $display("FAIL alu_fwd_mem_Ai got=%b exp=10", Ai); else n_pass++;
    n_total++; if (Bi !== 2'b00) $display("FAIL alu_fwd_mem_Bi got=%b exp=00", Bi); else n_pass++;
    // add $3, nop, sub rs=3: MEM/WB forward
    do_reset();
    drive_id(1, 2, 3, 1, 0, 1); tick();
    drive_id(0, 0, 0, 0, 0, 0); tick();
    drive_id(3, 4, 6, 1, 0, 1); tick();
    n_total++; if (Ai !== 2'b01) $display("FAIL alu_fwd_wb_Ai got=%b exp=01", Ai); else n_pass++;
    // dest $0 never forwards, from MEM or WB
    do_reset();
    drive_id(1, 2, 0, 1, 0, 1); tick();
    drive_id(0, 0, 0, 1, 0, 1); tick();
    n_total++; if (Ai !== 2'b00) $display("FAIL alu_fwd_r0_mem_Ai got=%b exp=00", Ai); else n_pass++;
    drive_id(0, 0, 0, 0, 0, 0); tick();
    n_total++; if (Ai !== 2'b00) $display("FAIL alu_fwd_r0_wb_Ai got=%b exp=00", Ai); else n_pass++;
    // two producers of $3: MEM (younger) wins over WB
    do_reset();
    drive_id(1, 2, 3, 1, 0, 1); tick();
    drive_id(4, 5, 3, 1, 0, 1); tick();
    drive_id(3, 3, 7, 1, 0, 1); tick();
    n_total++; if (Ai !== 2'b10) $display("FAIL alu_fwd_youngest_Ai got=%b exp=10", Ai); else n_pass++;
    n_total++; if (Bi !== 2'b10) $display("FAIL alu_fwd_youngest_Bi got=%b exp=10", Bi); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1, 5, 5, 1, 1, 0); tick();        // lw $5 now in EX
    drive_id(7, 5, 8, 1, 0, 1);                // add reads rt=$5
    n_total++; if (pc_write !== 1'b0) $display("FAIL lu_pc_write got=%b exp=0", pc_write); else n_pass++;
    n_total++; if (ifid_write !== 1'b0) $display("FAIL lu_ifid_write got=%b exp=0", ifid_write); else n_pass++;
    n_total++; if (idex_bubble !== 1'b1) $display("FAIL lu_idex_bubble got=%b exp=1", idex_bubble); else n_pass++;
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL lu_ifid_flush got=%b exp=0", ifid_flush); else n_pass++;
    tick();                                    // bubble in EX, lw in MEM
    n_total++; if (stall_count !== 4'd1) $display("FAIL lu_stall_count got=%0d exp=1", stall_count); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL lu_single_stall got=%b exp=1", pc_write); else n_pass++;
    tick();                                    // add in EX, lw in WB
    n_total++; if (Bi !== 2'b01) $display("FAIL lu_fwd_Bi got=%b exp=01", Bi); else n_pass++;
    n_total++; if (Ai !== 2'b00) $display("FAIL lu_fwd_Ai got=%b exp=00", Ai); else n_pass++;
    // same pair but rt not read: no hazard
    do_reset();
    drive_id(1, 5, 5, 1, 1, 0); tick();
    drive_id(7, 5, 8, 1, 0, 0);
    n_total++; if (pc_write !== 1'b1) $display("FAIL lu_nort_pc_write got=%b exp=1", pc_write); else n_pass++;
    n_total++; if (idex_bubble !== 1'b0) $display("FAIL lu_nort_idex_bubble got=%b exp=0", idex_bubble); else n_pass++;
    tick();
    n_total++; if (stall_count !== 4'd0) $display("FAIL lu_nort_stall_count got=%0d exp=0", stall_count); else n_pass++;
  endtask

  task automatic test_branch_flush();
    do_reset();
    drive_id(1, 2, 3, 1, 0, 1); tick();        // add $3 in EX
    branch_taken = 1'b1;
    drive_id(3, 3, 9, 1, 0, 1);
    n_total++; if (ifid_flush !== 1'b1) $display("FAIL br_ifid_flush got=%b exp=1", ifid_flush); else n_pass++;
    n_total++; if (idex_bubble !== 1'b1) $display("FAIL br_idex_bubble got=%b exp=1", idex_bubble); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL br_pc_write got=%b exp=1", pc_write); else n_pass++;
    tick();
    branch_taken = 1'b0;
    drive_id(3, 3, 9, 1, 0, 1);
    n_total++; if (flush_count !== 4'd1) $display("FAIL br_flush_count got=%0d exp=1", flush_count); else n_pass++;
    n_total++; if (Ai !== 2'b00) $display("FAIL br_bubble_Ai got=%b exp=00", Ai); else n_pass++;
    n_total++; if (Bi !== 2'b00) $display("FAIL br_bubble_Bi got=%b exp=00", Bi); else n_pass++;
  endtask

  task automatic test_freeze();
    do_reset();
    drive_id(1, 1, 2, 1, 0, 1); tick();        // add $2
    drive_id(2, 5, 5, 1, 1, 0); tick();        // lw $5 (rs=$2) in EX, add in MEM: Ai=10
    branch_taken = 1'b1; mem_stall = 1'b1;
    drive_id(7, 5, 8, 1, 0, 1);                // dependent of the load
    for (int i = 0; i < 3; i++) begin
      n_total++; if (pc_write !== 1'b0) $display("FAIL frz_pc_write[%0d] got=%b exp=0", i, pc_write); else n_pass++;
      n_total++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0)
        $display("FAIL frz_flush_bubble[%0d] got=%b%b exp=00", i, ifid_flush, idex_bubble); else n_pass++;
      n_total++; if (Ai !== 2'b10) $display("FAIL frz_Ai[%0d] got=%b exp=10", i, Ai); else n_pass++;
      n_total++; if (stall_count !== 4'd0 || flush_count !== 4'd0)
        $display("FAIL frz_counters[%0d] got=%0d/%0d exp=0/0", i, stall_count, flush_count); else n_pass++;
      tick();
    end
    mem_stall = 1'b0; #1;                      // flush outranks the pending load-use
    n_total++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1)
      $display("FAIL frz_release_flush got=%b%b exp=11", ifid_flush, pc_write); else n_pass++;
    tick();
    branch_taken = 1'b0; #1;
    n_total++; if (flush_count !== 4'd1) $display("FAIL frz_release_flush_count got=%0d exp=1", flush_count); else n_pass++;
    n_total++; if (stall_count !== 4'd0) $display("FAIL frz_release_stall_count got=%0d exp=0", stall_count); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL frz_release_no_stall got=%b exp=1", pc_write); else n_pass++;
    // reset wins over an active freeze
    mem_stall = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; mem_stall = 1'b0; #1;
    n_total++; if (flush_count !== 4'd0) $display("FAIL rst_over_freeze got=%0d exp=0", flush_count); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      drive_id(1, 5, 5, 1, 1, 0); tick();      // lw $5 into EX
      drive_id(5, 0, 6, 1, 0, 0); tick();      // dependent stalls once
      if (i == 3) begin
        n_total++; if (stall_count !== 4'd3) $display("FAIL sat_count_3 got=%0d exp=3", stall_count); else n_pass++;
      end
      if (i == 15) begin
        n_total++; if (stall_count !== 4'd15) $display("FAIL sat_count_15 got=%0d exp=15", stall_count); else n_pass++;
      end
    end
    n_total++; if (stall_count !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", stall_count); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; mem_stall = 1'b0;
    id_rs = 0; id_rt = 0; id_dest = 0;
    id_reg_write = 0; id_mem_read = 0; id_uses_rt = 0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_branch_flush();
    test_freeze();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
